// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The controller drives the selects and enables; the datapath returns the instruction fields and the ALU zero flag.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we;
    logic       ir_we;
    logic       iord;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ext_op;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pc_we, ir_we, iord, mem_we, reg_we, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, ext_op, alu_op, pc_src, state
    );

    modport slave (
        output op, funct, zero,
        input  pc_we, ir_we, iord, mem_we, reg_we, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, ext_op, alu_op, pc_src, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit for addu/subu/ori/lui/lw/sw/beq/j/jal.
// Outputs are combinational from the current state and the op/funct fields.
module mc_ctrl (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXE     = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9
    } state_e;

    state_e state_q, state_d;

    logic is_rtype, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

    // Instruction class decode from the IR fields.
    always_comb begin
        is_rtype = (bus.op == OP_RTYPE);
        is_addu  = is_rtype && (bus.funct == FN_ADDU);
        is_subu  = is_rtype && (bus.funct == FN_SUBU);
        is_ori   = (bus.op == OP_ORI);
        is_lui   = (bus.op == OP_LUI);
        is_lw    = (bus.op == OP_LW);
        is_sw    = (bus.op == OP_SW);
        is_beq   = (bus.op == OP_BEQ);
        is_j     = (bus.op == OP_J);
        is_jal   = (bus.op == OP_JAL);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign bus.state = state_q;

    always_comb begin
        state_d        = S_FETCH;
        bus.pc_we      = 1'b0;
        bus.ir_we      = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_we     = 1'b0;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 2'b00;
        bus.mem_to_reg = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.ext_op     = 2'b00;
        bus.alu_op     = ALU_ADDU;
        bus.pc_src     = 2'b00;
        // Reset holds every enable and select low so an aborted instruction writes nothing.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.ir_we     = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.pc_we     = 1'b1;
                    state_d       = S_DECODE;
                end
                S_DECODE: begin
                    bus.alu_src_b = 2'b11;
                    bus.ext_op    = 2'b01;
                    if (is_lw || is_sw)                           state_d = S_MEM_ADR;
                    else if (is_addu || is_subu || is_ori || is_lui) state_d = S_EXE;
                    else if (is_beq)                              state_d = S_BRANCH;
                    else if (is_j || is_jal)                      state_d = S_JUMP;
                    else                                          state_d = S_FETCH;
                end
                S_MEM_ADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.ext_op    = 2'b01;
                    state_d       = is_lw ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    bus.iord = 1'b1;
                    state_d  = S_MEM_WB;
                end
                S_MEM_WB: begin
                    bus.reg_we     = 1'b1;
                    bus.mem_to_reg = 2'b01;
                end
                S_MEM_WR: begin
                    bus.iord   = 1'b1;
                    bus.mem_we = 1'b1;
                end
                S_EXE: begin
                    bus.alu_src_a = 1'b1;
                    state_d       = S_ALU_WB;
                    if (is_subu) begin
                        bus.alu_op = ALU_SUBU;
                    end else if (is_ori) begin
                        bus.alu_src_b = 2'b10;
                        bus.alu_op    = ALU_OR;
                    end else if (is_lui) begin
                        bus.alu_src_b = 2'b10;
                        bus.ext_op    = 2'b10;
                        bus.alu_op    = ALU_OR;
                    end
                end
                S_ALU_WB: begin
                    bus.reg_we  = 1'b1;
                    bus.reg_dst = is_rtype ? 2'b01 : 2'b00;
                end
                S_BRANCH: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_SUBU;
                    bus.pc_src    = 2'b01;
                    bus.pc_we     = bus.zero;
                end
                S_JUMP: begin
                    bus.pc_src = 2'b10;
                    bus.pc_we  = 1'b1;
                    if (is_jal) begin
                        bus.reg_we     = 1'b1;
                        bus.reg_dst    = 2'b10;
                        bus.mem_to_reg = 2'b10;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: each issued instruction queues its expected per-cycle control word.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_ctrl_if bus ();
    mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    typedef enum int { K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_UND, K_RST } kind_e;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_we, ir_we, iord, mem_we, reg_we;
        logic [1:0] reg_dst, mem_to_reg;
        logic       src_a;
        logic [1:0] src_b, ext_op;
        logic [3:0] alu_op;
        logic [1:0] pc_src;
    } rec_t;

    typedef struct { rec_t r; kind_e k; } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic string kname(kind_e k);
        case (k)
            K_ADDU: return "addu"; K_SUBU: return "subu"; K_ORI: return "ori";
            K_LUI:  return "lui";  K_LW:   return "lw";   K_SW:  return "sw";
            K_BEQ:  return "beq";  K_J:    return "j";    K_JAL: return "jal";
            K_UND:  return "undef";
            default: return "reset";
        endcase
    endfunction

    // Expected control word for instruction kind k while it sits in state st.
    function automatic rec_t model(kind_e k, int st, logic z);
        rec_t r = '0;
        r.state = 4'(st);
        case (st)
            0: begin r.ir_we = 1'b1; r.src_b = 2'b01; r.pc_we = 1'b1; end
            1: begin r.src_b = 2'b11; r.ext_op = 2'b01; end
            2: begin r.src_a = 1'b1; r.src_b = 2'b10; r.ext_op = 2'b01; end
            3: r.iord = 1'b1;
            4: begin r.reg_we = 1'b1; r.mem_to_reg = 2'b01; end
            5: begin r.iord = 1'b1; r.mem_we = 1'b1; end
            6: begin
                r.src_a = 1'b1;
                if (k == K_SUBU) r.alu_op = 4'b0001;
                if (k == K_ORI) begin r.src_b = 2'b10; r.alu_op = 4'b0010; end
                if (k == K_LUI) begin r.src_b = 2'b10; r.ext_op = 2'b10; r.alu_op = 4'b0010; end
            end
            7: begin r.reg_we = 1'b1; r.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00; end
            8: begin r.src_a = 1'b1; r.alu_op = 4'b0001; r.pc_src = 2'b01; r.pc_we = z; end
            9: begin
                r.pc_src = 2'b10; r.pc_we = 1'b1;
                if (k == K_JAL) begin r.reg_we = 1'b1; r.reg_dst = 2'b10; r.mem_to_reg = 2'b10; end
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic bit defined(logic [5:0] op, logic [5:0] fn);
        if (op == 6'b000000) return (fn == 6'b100001) || (fn == 6'b100011);
        return op inside {6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
    endfunction

    task automatic encode(input kind_e k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (k)
            K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
            K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
            K_ORI:  op = 6'b001101;
            K_LUI:  op = 6'b001111;
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            K_BEQ:  op = 6'b000100;
            K_J:    op = 6'b000010;
            K_JAL:  op = 6'b000011;
            default: begin
                do begin
                    op = ($urandom_range(0, 1) == 0) ? 6'b000000 : 6'($urandom);
                    fn = 6'($urandom);
                end while (defined(op, fn));
            end
        endcase
    endtask

    // Drive one instruction from FETCH, queue its whole state walk, and wait it out.
    task automatic issue(input kind_e k, input logic [5:0] op, input logic [5:0] fn, input logic z);
        int p[$];
        exp_t e;
        bus.op = op; bus.funct = fn; bus.zero = z;
        p = '{0, 1};
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI: begin p.push_back(6); p.push_back(7); end
            K_LW:  begin p.push_back(2); p.push_back(3); p.push_back(4); end
            K_SW:  begin p.push_back(2); p.push_back(5); end
            K_BEQ: p.push_back(8);
            K_J, K_JAL: p.push_back(9);
            default: ;
        endcase
        foreach (p[i]) begin e.r = model(k, p[i], z); e.k = k; q.push_back(e); end
        repeat (p.size()) @(posedge clk);
        #1;
    endtask

    task automatic issue_kind(input kind_e k, input logic z);
        logic [5:0] op, fn;
        encode(k, op, fn);
        issue(k, op, fn, z);
    endtask

    task automatic push_reset_rec(input int st);
        exp_t e;
        e.r = '0; e.r.state = 4'(st); e.k = K_RST;
        q.push_back(e);
    endtask

    // Abort an addu in EXE by holding reset for two cycles.
    task automatic reset_mid_exe();
        exp_t e;
        bus.op = 6'b000000; bus.funct = 6'b100001; bus.zero = 1'b0;
        e.k = K_ADDU;
        e.r = model(K_ADDU, 0, 1'b0); q.push_back(e);
        e.r = model(K_ADDU, 1, 1'b0); q.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push_reset_rec(6);
        push_reset_rec(0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every cycle with an outstanding expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            rec_t got;
            e = q.pop_front();
            got = '{bus.state, bus.pc_we, bus.ir_we, bus.iord, bus.mem_we, bus.reg_we,
                    bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                    bus.ext_op, bus.alu_op, bus.pc_src};
            n_cmp++;
            if (got !== e.r) begin
                n_bad++;
                $display("FAIL %s st%0d: got %h required %h", kname(e.k), e.r.state, got, e.r);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
        @(posedge clk);
        #1;
        push_reset_rec(0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue_kind(K_ADDU, 1'b0);
        issue_kind(K_LW, 1'b0);
        issue_kind(K_SW, 1'b1);
        issue_kind(K_BEQ, 1'b1);
        issue_kind(K_BEQ, 1'b0);
        issue_kind(K_LUI, 1'b0);
        issue_kind(K_ORI, 1'b1);
        issue_kind(K_JAL, 1'b0);
        issue(K_UND, 6'b111111, 6'($urandom), 1'b1);
        issue_kind(K_SUBU, 1'b0);
        issue_kind(K_J, 1'b1);
        issue(K_UND, 6'b000000, 6'b100000, 1'b0);
        reset_mid_exe();
        issue_kind(K_ADDU, 1'b1);

        for (int n = 0; n < 300; n++) begin
            kind_e k;
            k = kind_e'($urandom_range(0, 9));
            issue_kind(k, 1'($urandom));
        end

        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit; initiator side of the datapath ALU interface.
- Decodes op/funct from the instruction register and sequences each instruction through fetch/decode/execute/memory/writeback states.
- Each cycle it drives ALU opcode, operand selects, mux selects and write enables, and consumes the ALU zero flag for branches.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal.

Parameters:
- ALU_ADDU, 4'b0000, ALU opcode for add.
- ALU_SUBU, 4'b0001, ALU opcode for subtract.
- ALU_OR, 4'b0010, ALU opcode for bitwise or.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (1 when A-B==0, independent of opcode).
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_we  out  1  data memory write enable.
- reg_we  out  1  register file write enable.
- reg_dst  out  2  write register select: 00=rt, 01=rd, 10=$31.
- mem_to_reg  out  2  write data select: 00=ALUOut, 01=MDR, 10=PC.
- alu_src_a  out  1  ALU A select: 0=PC, 1=reg A.
- alu_src_b  out  2  ALU B select: 00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2.
- ext_op  out  2  immediate extender: 00=zero, 01=sign, 10=imm<<16.
- alu_op  out  4  ALU opcode.
- pc_src  out  2  next PC select: 00=ALU result, 01=ALUOut, 10={PC[31:28],index,2'b00}.
- state  out  4  current state, for debug and verification.

Behaviour:
- Single clk domain. Reset is synchronous and active-high; ports are named clk and reset.
- Reset: state<=FETCH on the edge. While reset is high, all write enables (pc_we, ir_we, mem_we, reg_we) are forced to 0 and all selects/alu_op are 0.
- Reset asserted mid-instruction aborts it. There are no partial writes after the reset edge.
- Outputs are combinational from state plus op/funct. pc_we in BRANCH also depends on zero.
- Any output not listed for a state is 0.
- Decodes:
  - R-type: op=000000, with funct 100001=addu, 100011=subu.
  - ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
- State encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXE=6, ALU_WB=7, BRANCH=8, JUMP=9.
- FETCH: ir_we=1, iord=0, src_a=0, src_b=01, alu_op=ADDU, pc_src=00, pc_we=1. Next state is DECODE.
- DECODE: src_a=0, src_b=11, ext_op=01, alu_op=ADDU; the branch target is latched into ALUOut. Next state:
  - lw/sw -> MEM_ADR.
  - addu/subu/ori/lui -> EXE.
  - beq -> BRANCH.
  - j/jal -> JUMP.
  - Anything else, including R-type with another funct -> FETCH (executes as nop; no writes).
- MEM_ADR: src_a=1, src_b=10, ext_op=01, alu_op=ADDU. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1. Next state is MEM_WB.
- MEM_WB: reg_we=1, reg_dst=00, mem_to_reg=01. Next state is FETCH.
- MEM_WR: iord=1, mem_we=1. Next state is FETCH.
- EXE: src_a=1. Next state is ALU_WB.
  - addu/subu: src_b=00, alu_op=ADDU/SUBU.
  - ori: src_b=10, ext_op=00, alu_op=OR.
  - lui: src_b=10, ext_op=10, alu_op=OR (rs field is $0).
- ALU_WB: reg_we=1, reg_dst=01 for R-type, 00 otherwise, mem_to_reg=00. Next state is FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=SUBU, pc_src=01, pc_we=zero. Next state is FETCH.
- JUMP: pc_src=10, pc_we=1. Next state is FETCH.
  - jal additionally: reg_we=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4).
- Cycles per instruction, FETCH to FETCH:
  - beq, j, jal: 3.
  - addu, subu, ori, lui, sw: 4.
  - lw: 5.
  - Undefined: 2.
- Exactly one pc_we=1 cycle in FETCH per instruction, plus at most one in BRANCH or JUMP.
- reg_we and mem_we are never both 1.
- Unreachable state codes 10-15 go to FETCH on the next edge, with all outputs 0.

Test Plan:
- Reset: hold reset 2 cycles mid-EXE -> state=0 on the following edge; pc_we, ir_we, mem_we, reg_we all 0 while reset is high.
- addu (op=0, funct=100001) -> states 0,1,6,7,0. In EXE: alu_op=0000, src_b=00. In ALU_WB: reg_we=1, reg_dst=01.
- lw then sw -> lw visits 0,1,2,3,4 with mem_to_reg=01 and reg_we=1 in state 4. sw visits 0,1,2,5 with mem_we=1, iord=1 in state 5.
- beq with zero=1, then zero=0 -> in BRANCH: alu_op=0001, pc_src=01, and pc_we=1 for zero=1, pc_we=0 for zero=0.
- lui and ori -> in EXE: alu_op=0010, src_b=10, ext_op=10 for lui and 00 for ori. In ALU_WB: reg_dst=00.
- jal and an undefined op (111111) -> jal visits 0,1,9 with pc_src=10, reg_we=1, reg_dst=10, mem_to_reg=10. The undefined op visits 0,1,0 with no reg_we/mem_we pulse.
